// File: rtl/core_axi_pkg.sv
// Shared AXI4 encodings and bridge FSM state types for the D-cache memory bridge.
package core_axi_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_DONE} wr_state_t;

endpackage

// File: rtl/core_axi_beat_assembler.sv
// Collects read-burst beats into a cache block; beat i lands in slot i.
module core_axi_beat_assembler #(
  parameter int unsigned BUS_WIDTH   = 64,
  parameter int unsigned BLOCK_WIDTH = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   beat_valid,
  input  logic [BUS_WIDTH-1:0]   beat_data,
  output logic                   last_beat,
  output logic [BLOCK_WIDTH-1:0] block
);

  localparam int unsigned BEATS = BLOCK_WIDTH / BUS_WIDTH;
  localparam int unsigned CNT_W = $clog2(BEATS);

  logic [CNT_W-1:0] beat_cnt;

  // The counter wraps to slot 0 after the last beat, so every burst starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      block    <= '0;
    end else if (beat_valid) begin
      block[32'(beat_cnt) * BUS_WIDTH +: BUS_WIDTH] <= beat_data;
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

endmodule

// File: rtl/core_dcache_axi_bridge.sv
// D-cache to AXI4 master bridge: 4-beat block refills and single-beat word writes.
// Optional sticky response checking is enabled by DCACHE_BRIDGE_RESP_CHECK_EN.
module core_dcache_axi_bridge #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned BUS_WIDTH   = 64,
  parameter int unsigned BLOCK_WIDTH = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_mem_read_req,
  input  logic [ADDR_WIDTH-1:0]   i_mem_read_address,
  output logic                    o_mem_read_done,
  output logic [BLOCK_WIDTH-1:0]  o_block_to_cache,
  input  logic                    i_mem_write_valid,
  input  logic [ADDR_WIDTH-1:0]   i_mem_write_address,
  input  logic [BUS_WIDTH-1:0]    i_mem_write_data,
  input  logic [BUS_WIDTH/8-1:0]  i_mem_write_strobe,
  output logic                    o_mem_write_done,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [BUS_WIDTH-1:0]    m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]              m_awlen,
  output logic [2:0]              m_awsize,
  output logic [1:0]              m_awburst,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [BUS_WIDTH-1:0]    m_wdata,
  output logic [BUS_WIDTH/8-1:0]  m_wstrb,
  output logic                    m_wlast,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic                    o_bus_error
);

  import core_axi_pkg::*;

  localparam int unsigned BEATS    = BLOCK_WIDTH / BUS_WIDTH;
  localparam int unsigned BLK_OFF  = $clog2(BLOCK_WIDTH / 8);
  localparam int unsigned WORD_OFF = $clog2(BUS_WIDTH / 8);

  rd_state_t rd_state, rd_next;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic rd_fire, last_beat;

  assign rd_fire = m_rvalid && (rd_state == R_DATA);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rd_state <= R_IDLE;
    else          rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (i_mem_read_req) rd_next = R_ADDR;
      R_ADDR:  if (m_arready) rd_next = R_DATA;
      R_DATA:  if (rd_fire && last_beat) rd_next = R_DONE;
      R_DONE:  rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    m_arvalid       = 1'b0;
    m_araddr        = '0;
    m_arlen         = '0;
    m_arsize        = '0;
    m_arburst       = '0;
    m_rready        = 1'b0;
    o_mem_read_done = 1'b0;
    case (rd_state)
      R_ADDR: begin
        m_arvalid = 1'b1;
        m_araddr  = rd_addr;
        m_arlen   = 8'(BEATS - 1);
        m_arsize  = AXI_SIZE_8B;
        m_arburst = INCR;
      end
      R_DATA:  m_rready = 1'b1;
      R_DONE:  o_mem_read_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rd_addr <= '0;
    else if (rd_state == R_IDLE && i_mem_read_req)
      rd_addr <= {i_mem_read_address[ADDR_WIDTH-1:BLK_OFF], {BLK_OFF{1'b0}}};
  end

  core_axi_beat_assembler #(
    .BUS_WIDTH  (BUS_WIDTH),
    .BLOCK_WIDTH(BLOCK_WIDTH)
  ) u_beat_asm (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .beat_valid(rd_fire),
    .beat_data (m_rdata),
    .last_beat (last_beat),
    .block     (o_block_to_cache)
  );

  wr_state_t wr_state, wr_next;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [BUS_WIDTH-1:0]   wr_data;
  logic [BUS_WIDTH/8-1:0] wr_strb;
  logic aw_done, w_done, aw_fire, w_fire, b_fire;

  assign aw_fire = m_awvalid && m_awready;
  assign w_fire  = m_wvalid && m_wready;
  assign b_fire  = m_bvalid && (wr_state == W_RESP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) wr_state <= W_IDLE;
    else          wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (i_mem_write_valid) wr_next = W_REQ;
      W_REQ:   if ((aw_done || aw_fire) && (w_done || w_fire)) wr_next = W_RESP;
      W_RESP:  if (b_fire) wr_next = W_DONE;
      W_DONE:  wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    m_awvalid        = 1'b0;
    m_awaddr         = '0;
    m_awlen          = '0;
    m_awsize         = '0;
    m_awburst        = '0;
    m_wvalid         = 1'b0;
    m_wdata          = '0;
    m_wstrb          = '0;
    m_wlast          = 1'b0;
    m_bready         = 1'b0;
    o_mem_write_done = 1'b0;
    case (wr_state)
      W_REQ: begin
        m_awvalid = !aw_done;
        m_awaddr  = wr_addr;
        m_awsize  = AXI_SIZE_8B;
        m_awburst = INCR;
        m_wvalid  = !w_done;
        m_wdata   = wr_data;
        m_wstrb   = wr_strb;
        m_wlast   = 1'b1;
      end
      W_RESP:  m_bready = 1'b1;
      W_DONE:  o_mem_write_done = 1'b1;
      default: ;
    endcase
  end

  // AW and W complete independently; each done flag retires its own valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_addr <= '0;
      wr_data <= '0;
      wr_strb <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (wr_state == W_IDLE && i_mem_write_valid) begin
      wr_addr <= {i_mem_write_address[ADDR_WIDTH-1:WORD_OFF], {WORD_OFF{1'b0}}};
      wr_data <= i_mem_write_data;
      wr_strb <= i_mem_write_strobe;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_mem_read_address[BLK_OFF-1:0], i_mem_write_address[WORD_OFF-1:0]};

`ifdef DCACHE_BRIDGE_RESP_CHECK_EN
  logic bus_error;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) bus_error <= 1'b0;
    else if ((rd_fire && (m_rresp != OKAY || m_rlast != last_beat)) ||
             (b_fire && m_bresp != OKAY))
      bus_error <= 1'b1;
  end
  assign o_bus_error = bus_error;
`else
  logic unused_resp;
  assign unused_resp = ^{m_rresp, m_rlast, m_bresp};
  assign o_bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_core_dcache_axi_bridge.sv
// Directed bench for core_dcache_axi_bridge with a small AXI slave responder.
`timescale 1ns/1ps
module tb_core_dcache_axi_bridge;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_mem_read_req = 1'b0;
  logic [63:0]  i_mem_read_address = '0;
  logic         o_mem_read_done;
  logic [255:0] o_block_to_cache;
  logic         i_mem_write_valid = 1'b0;
  logic [63:0]  i_mem_write_address = '0;
  logic [63:0]  i_mem_write_data = '0;
  logic [7:0]   i_mem_write_strobe = '0;
  logic         o_mem_write_done;
  logic [63:0]  m_araddr;
  logic [7:0]   m_arlen;
  logic [2:0]   m_arsize;
  logic [1:0]   m_arburst;
  logic         m_arvalid;
  logic         m_arready = 1'b0;
  logic [63:0]  m_rdata = '0;
  logic [1:0]   m_rresp = '0;
  logic         m_rlast = 1'b0;
  logic         m_rvalid = 1'b0;
  logic         m_rready;
  logic [63:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awsize;
  logic [1:0]   m_awburst;
  logic         m_awvalid;
  logic         m_awready = 1'b0;
  logic [63:0]  m_wdata;
  logic [7:0]   m_wstrb;
  logic         m_wlast;
  logic         m_wvalid;
  logic         m_wready = 1'b0;
  logic [1:0]   m_bresp = '0;
  logic         m_bvalid = 1'b0;
  logic         m_bready;
  logic         o_bus_error;

  core_dcache_axi_bridge #(
    .ADDR_WIDTH (64),
    .BUS_WIDTH  (64),
    .BLOCK_WIDTH(256)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mem_read_req(i_mem_read_req), .i_mem_read_address(i_mem_read_address),
    .o_mem_read_done(o_mem_read_done), .o_block_to_cache(o_block_to_cache),
    .i_mem_write_valid(i_mem_write_valid), .i_mem_write_address(i_mem_write_address),
    .i_mem_write_data(i_mem_write_data), .i_mem_write_strobe(i_mem_write_strobe),
    .o_mem_write_done(o_mem_write_done),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
    .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .o_bus_error(o_bus_error)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Read slave: first beat one cycle after AR acceptance, then per-beat gaps.
  logic [63:0] rd_beats [4];
  int          rd_gaps  [4];
  logic [1:0]  rd_resps [4];
  int rs_beat = 0, rs_wait = 0, ar_count = 0, r2_cyc = -1;
  bit rs_busy = 0, ar_pf = 0, r_pf = 0;
  logic [63:0] cap_araddr = '0;
  logic [7:0]  cap_arlen = '0;
  logic [2:0]  cap_arsize = '0;
  logic [1:0]  cap_arburst = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
      rs_busy = 0; ar_pf = 0; r_pf = 0; rs_beat = 0; rs_wait = 0;
    end else begin
      if (ar_pf) begin rs_busy = 1; rs_beat = 0; rs_wait = rd_gaps[0] + 1; end
      if (r_pf) begin
        rs_beat++;
        if (rs_beat == 4) rs_busy = 0;
        else rs_wait = rd_gaps[rs_beat];
      end
      m_arready = 1'b1;
      m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
      if (rs_busy) begin
        if (rs_wait > 0) rs_wait--;
        else begin
          m_rvalid = 1'b1; m_rdata = rd_beats[rs_beat];
          m_rresp = rd_resps[rs_beat]; m_rlast = (rs_beat == 3);
        end
      end
      ar_pf = m_arvalid && m_arready;
      if (ar_pf) begin
        ar_count++;
        cap_araddr = m_araddr; cap_arlen = m_arlen; cap_arsize = m_arsize; cap_arburst = m_arburst;
      end
      r_pf = m_rvalid && m_rready;
      if (r_pf && rs_beat == 2) r2_cyc = cyc;
    end
  end

  // Write slave: independent AW/W ready delays, then B after b_delay cycles.
  int aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [1:0] b_resp_cfg = 2'b00;
  int aw_wait = 0, w_wait = 0, b_wait = 0, b_fire_cyc = -100;
  bit aw_got = 0, w_got = 0, aw_pf = 0, w_pf = 0, b_pf = 0;
  logic [63:0] cap_awaddr = '0, cap_wdata = '0;
  logic [7:0]  cap_awlen = '0, cap_wstrb = '0;
  logic [2:0]  cap_awsize = '0;
  logic [1:0]  cap_awburst = '0;
  logic        cap_wlast = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
      aw_got = 0; w_got = 0; aw_pf = 0; w_pf = 0; b_pf = 0;
    end else begin
      if (aw_pf) aw_got = 1;
      if (w_pf)  w_got = 1;
      if (b_pf) begin aw_got = 0; w_got = 0; end
      m_awready = 1'b0;
      if (m_awvalid && !aw_got) begin
        if (aw_wait > 0) aw_wait--; else m_awready = 1'b1;
      end else aw_wait = aw_delay;
      m_wready = 1'b0;
      if (m_wvalid && !w_got) begin
        if (w_wait > 0) w_wait--; else m_wready = 1'b1;
      end else w_wait = w_delay;
      m_bvalid = 1'b0; m_bresp = '0;
      if (aw_got && w_got) begin
        if (b_wait > 0) b_wait--;
        else begin m_bvalid = 1'b1; m_bresp = b_resp_cfg; end
      end else b_wait = b_delay;
      aw_pf = m_awvalid && m_awready;
      if (aw_pf) begin
        cap_awaddr = m_awaddr; cap_awlen = m_awlen; cap_awsize = m_awsize; cap_awburst = m_awburst;
      end
      w_pf = m_wvalid && m_wready;
      if (w_pf) begin cap_wdata = m_wdata; cap_wstrb = m_wstrb; cap_wlast = m_wlast; end
      b_pf = m_bvalid && m_bready;
      if (b_pf) b_fire_cyc = cyc;
    end
  end

  int err_rise_cyc = -1;
  logic err_prev = 1'b0;
  initial forever begin
    @(negedge clk);
    if (o_bus_error && !err_prev) err_rise_cyc = cyc;
    err_prev = o_bus_error;
  end

  // Returns cycles from request to done (-1 on timeout) and the block seen with done.
  task automatic do_read(input logic [63:0] addr, output int lat, output logic [255:0] blk);
    int t0, n;
    i_mem_read_address = addr;
    i_mem_read_req = 1'b1;
    t0 = cyc; n = 0;
    do begin @(negedge clk); n++; end while (!o_mem_read_done && n < 100);
    lat = o_mem_read_done ? cyc - t0 : -1;
    blk = o_block_to_cache;
    i_mem_read_req = 1'b0;
  endtask

  // Returns cycles from B handshake to write done (-1 on timeout).
  task automatic wait_wr_done(output int lat);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_mem_write_done && n < 100);
    lat = o_mem_write_done ? cyc - b_fire_cyc : -1;
    i_mem_write_valid = 1'b0;
  endtask

  initial begin
    int lat, rd_seen, wr_seen, ar0, hold;
    logic [255:0] blk;
    for (int k = 0; k < 4; k++) begin rd_gaps[k] = 0; rd_resps[k] = 2'b00; rd_beats[k] = '0; end
    repeat (3) @(negedge clk);

    check("rst_read_done", 256'(o_mem_read_done), 256'(0));
    check("rst_write_done", 256'(o_mem_write_done), 256'(0));
    check("rst_valids", 256'({m_arvalid, m_awvalid, m_wvalid}), 256'(0));
    check("rst_readies", 256'({m_rready, m_bready}), 256'(0));
    check("rst_ar_fields", 256'({m_araddr, m_arlen, m_arsize, m_arburst}), 256'(0));
    check("rst_aw_fields", 256'({m_awaddr, m_awlen, m_awsize, m_awburst, m_wlast}), 256'(0));
    check("rst_block", o_block_to_cache, 256'(0));
    check("rst_bus_error", 256'(o_bus_error), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: zero-wait refill
    rd_beats[0] = 64'h1111_1111_1111_1111; rd_beats[1] = 64'h2222_2222_2222_2222;
    rd_beats[2] = 64'h3333_3333_3333_3333; rd_beats[3] = 64'h4444_4444_4444_4444;
    ar0 = ar_count;
    do_read(64'h0000_0000_8000_1234, lat, blk);
    check("t1_latency", 256'(lat), 256'(7));
    check("t1_block", blk, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    check("t1_araddr", 256'(cap_araddr), 256'(64'h0000_0000_8000_1220));
    check("t1_arlen_size_burst", 256'({cap_arlen, cap_arsize, cap_arburst}),
          256'({8'd3, 3'd3, 2'b01}));
    @(negedge clk);
    check("t1_done_pulse_width", 256'(o_mem_read_done), 256'(0));
    check("t1_ar_count", 256'(ar_count - ar0), 256'(1));
    check("t1_block_held", o_block_to_cache, blk);

    // 2: single write, awready three cycles after wready
    aw_delay = 3; w_delay = 0; b_delay = 2;
    @(negedge clk);
    i_mem_write_address = 64'h0000_0000_8000_0107;
    i_mem_write_data = 64'hDEAD_BEEF_0000_0001;
    i_mem_write_strobe = 8'h0F;
    i_mem_write_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("t2_wvalid_dropped_awvalid_held", 256'({m_wvalid, m_awvalid}), 256'(2'b01));
    wait_wr_done(lat);
    check("t2_done_after_b", 256'(lat), 256'(1));
    check("t2_awaddr", 256'(cap_awaddr), 256'(64'h0000_0000_8000_0100));
    check("t2_aw_len_size_burst", 256'({cap_awlen, cap_awsize, cap_awburst}),
          256'({8'd0, 3'd3, 2'b01}));
    check("t2_wdata", 256'(cap_wdata), 256'(64'hDEAD_BEEF_0000_0001));
    check("t2_wstrb_wlast", 256'({cap_wstrb, cap_wlast}), 256'({8'h0F, 1'b1}));
    @(negedge clk);
    check("t2_done_pulse_width", 256'(o_mem_write_done), 256'(0));

    // 3: gapped burst, request held through the done cycle
    aw_delay = 0;
    rd_beats[0] = 64'hA0A0_0000_0000_0001; rd_beats[1] = 64'hA0A0_0000_0000_0002;
    rd_beats[2] = 64'hA0A0_0000_0000_0003; rd_beats[3] = 64'hA0A0_0000_0000_0004;
    rd_gaps = '{0, 2, 5, 1};
    ar0 = ar_count; rd_seen = 0; hold = 0; blk = '0;
    i_mem_read_address = 64'h0000_0000_0000_2040;
    i_mem_read_req = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (hold > 0) i_mem_read_req = 1'b0;
      if (o_mem_read_done) begin rd_seen++; blk = o_block_to_cache; hold = 1; end
    end
    check("t3_block", blk, {64'hA0A0_0000_0000_0004, 64'hA0A0_0000_0000_0003,
                            64'hA0A0_0000_0000_0002, 64'hA0A0_0000_0000_0001});
    check("t3_done_once", 256'(rd_seen), 256'(1));
    check("t3_single_ar", 256'(ar_count - ar0), 256'(1));
    check("t3_araddr", 256'(cap_araddr), 256'(64'h0000_0000_0000_2040));

    // 4: concurrent read and write, zero strobe
    rd_gaps = '{0, 0, 0, 0}; b_delay = 0;
    rd_beats[0] = 64'h5555_5555_5555_5555; rd_beats[1] = 64'h6666_6666_6666_6666;
    rd_beats[2] = 64'h7777_7777_7777_7777; rd_beats[3] = 64'h8888_8888_8888_8888;
    @(negedge clk);
    rd_seen = 0; wr_seen = 0; blk = '0;
    i_mem_read_address = 64'h0000_0000_0000_0040; i_mem_read_req = 1'b1;
    i_mem_write_address = 64'h0000_0000_1000_001F; i_mem_write_data = 64'h0123_4567_89AB_CDEF;
    i_mem_write_strobe = 8'h00; i_mem_write_valid = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (o_mem_read_done) begin rd_seen++; blk = o_block_to_cache; i_mem_read_req = 1'b0; end
      if (o_mem_write_done) begin wr_seen++; i_mem_write_valid = 1'b0; end
    end
    check("t4_read_done_once", 256'(rd_seen), 256'(1));
    check("t4_write_done_once", 256'(wr_seen), 256'(1));
    check("t4_block", blk, {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                            64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555});
    check("t4_awaddr", 256'(cap_awaddr), 256'(64'h0000_0000_1000_0018));
    check("t4_wstrb_zero", 256'({cap_wstrb, cap_wdata}), 256'({8'h00, 64'h0123_4567_89AB_CDEF}));

    // 5: SLVERR on beat 2, then DECERR on a write
    rd_beats[0] = 64'h9999_9999_9999_9999; rd_beats[1] = 64'hAAAA_AAAA_AAAA_AAAA;
    rd_beats[2] = 64'hBBBB_BBBB_BBBB_BBBB; rd_beats[3] = 64'hCCCC_CCCC_CCCC_CCCC;
    rd_resps[2] = 2'b10;
    check("t5_error_before", 256'(o_bus_error), 256'(0));
    do_read(64'h0000_0000_0000_0100, lat, blk);
    check("t5_block_still_delivered", blk, {64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB,
                                            64'hAAAA_AAAA_AAAA_AAAA, 64'h9999_9999_9999_9999});
    rd_resps[2] = 2'b00;
    b_resp_cfg = 2'b11;
    @(negedge clk);
    i_mem_write_address = 64'h0000_0000_0000_0200; i_mem_write_data = 64'h1;
    i_mem_write_strobe = 8'hFF; i_mem_write_valid = 1'b1;
    wait_wr_done(lat);
    check("t5_write_done", 256'(lat), 256'(1));
    b_resp_cfg = 2'b00;
    repeat (3) @(negedge clk);
`ifdef DCACHE_BRIDGE_RESP_CHECK_EN
    check("t5_error_sticky", 256'(o_bus_error), 256'(1));
    check("t5_error_rise_at_beat2", 256'(err_rise_cyc), 256'(r2_cyc + 1));
`else
    check("t5_error_tied_low", 256'(o_bus_error), 256'(0));
`endif

    // 6: reset while waiting for beat 1, then a clean refill
    rd_gaps = '{0, 3, 0, 0};
    for (int k = 0; k < 4; k++) rd_beats[k] = 64'hD1D1_0000_0000_0000 | 64'(k);
    @(negedge clk);
    i_mem_read_address = 64'h0000_0000_0000_3000; i_mem_read_req = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_valids_cleared", 256'({m_arvalid, m_awvalid, m_wvalid}), 256'(0));
    check("t6_readies_cleared", 256'({m_rready, m_bready}), 256'(0));
    check("t6_dones_cleared", 256'({o_mem_read_done, o_mem_write_done}), 256'(0));
    check("t6_block_cleared", o_block_to_cache, 256'(0));
    check("t6_error_cleared", 256'(o_bus_error), 256'(0));
    i_mem_read_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd_gaps = '{0, 0, 0, 0};
    for (int k = 0; k < 4; k++) rd_beats[k] = 64'hF0F0_0000_0000_0000 | 64'(k);
    @(negedge clk);
    do_read(64'h0000_0000_0000_3000, lat, blk);
    check("t6_fresh_latency", 256'(lat), 256'(7));
    check("t6_fresh_block", blk, {64'hF0F0_0000_0000_0003, 64'hF0F0_0000_0000_0002,
                                  64'hF0F0_0000_0000_0001, 64'hF0F0_0000_0000_0000});

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
